// File: rtl/pair_triple_sweep_checker.sv
// Self-test driver for a 3-input 2-of-3 majority detector.
// Sweeps all eight input patterns, compares each against golden majority, and reports the results.
module pair_triple_sweep_checker #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_start,
  output logic             o_det_in0,
  output logic             o_det_in1,
  output logic             o_det_in2,
  input  logic             i_det_out,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_pass,
  output logic [ERR_W-1:0] o_err_count,
  output logic             o_first_fail_valid,
  output logic [2:0]       o_first_fail_idx
);

  // state   | meaning
  // IDLE    | waiting for start, det_in* = 0
  // DRIVE   | pattern idx applied, settle down-counter running
  // SAMPLE  | det_out compared with golden at the closing edge
  // DONE    | results held until restart
  typedef enum logic [1:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_DONE} state_t;

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_idx;
  logic [CNT_W-1:0] r_wait;
  logic [2:0]       r_det;
  logic [ERR_W-1:0] r_err;
  logic             r_ffv;
  logic [2:0]       r_ffi;

  logic w_start_sweep;
  logic w_last;
  logic w_golden;
  logic w_mismatch;

  assign w_start_sweep = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last        = (r_idx == 3'd7);
  assign w_golden      = (r_idx[2] & r_idx[1]) | (r_idx[1] & r_idx[0]) | (r_idx[2] & r_idx[0]);
  assign w_mismatch    = (i_det_out != w_golden);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_start) w_next = S_DRIVE;
      S_DRIVE:  if (r_wait == '0) w_next = S_SAMPLE;
      S_SAMPLE: w_next = w_last ? S_DONE : S_DRIVE;
      S_DONE:   if (i_start) w_next = S_DRIVE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      S_DRIVE, S_SAMPLE: o_busy = 1'b1;
      S_DONE:            o_done = 1'b1;
      default:           ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_idx  <= '0;
      r_wait <= '0;
      r_det  <= '0;
      r_err  <= '0;
      r_ffv  <= 1'b0;
      r_ffi  <= '0;
    end else if (w_start_sweep) begin
      r_idx  <= '0;
      r_wait <= CNT_LOAD;
      r_det  <= '0;
      r_err  <= '0;
      r_ffv  <= 1'b0;
      r_ffi  <= '0;
    end else begin
      case (r_state)
        S_DRIVE: if (r_wait != '0) r_wait <= r_wait - CNT_W'(1);
        S_SAMPLE: begin
          // Saturating count; only the first mismatch records its index.
          if (w_mismatch && (r_err != '1)) r_err <= r_err + ERR_W'(1);
          if (w_mismatch && !r_ffv) begin
            r_ffv <= 1'b1;
            r_ffi <= r_idx;
          end
          if (w_last) begin
            r_det <= '0;
          end else begin
            r_idx  <= r_idx + 3'd1;
            r_det  <= r_idx + 3'd1;
            r_wait <= CNT_LOAD;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_det_in0          = r_det[2];
  assign o_det_in1          = r_det[1];
  assign o_det_in2          = r_det[0];
  assign o_err_count        = r_err;
  assign o_first_fail_valid = r_ffv;
  assign o_first_fail_idx   = r_ffi;
  assign o_pass             = o_done && (r_err == '0);

endmodule

// File: tb/tb_pair_triple_sweep_checker.sv
// Bench for pair_triple_sweep_checker: behavioural detector models plus a result scoreboard.
// A second instance with ERR_W=2 always sees an inverted-majority detector.
module tb_pair_triple_sweep_checker;

  localparam int M_IDEAL = 0;
  localparam int M_STUCK = 1;
  localparam int M_OR    = 2;
  localparam int M_INV   = 3;

  typedef struct {
    int err;
    int ffv;
    int ffi;
    int pass;
    int err2;
    int ffv2;
    int ffi2;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  int         mode = M_IDEAL;

  logic       in0, in1, in2, det_out, busy, done, pass, ffv;
  logic [3:0] err;
  logic [2:0] ffi;
  logic       b_in0, b_in1, b_in2, b_det_out, b_busy, b_done, b_pass, b_ffv;
  logic [1:0] b_err;
  logic [2:0] b_ffi;

  int   n_chk  = 0;
  int   n_fail = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  pair_triple_sweep_checker #(.SETTLE_CYCLES(1), .ERR_W(4)) dut (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_det_in0(in0), .o_det_in1(in1), .o_det_in2(in2), .i_det_out(det_out),
    .o_busy(busy), .o_done(done), .o_pass(pass), .o_err_count(err),
    .o_first_fail_valid(ffv), .o_first_fail_idx(ffi)
  );

  pair_triple_sweep_checker #(.SETTLE_CYCLES(1), .ERR_W(2)) dut2 (
    .i_clk(clk), .i_reset(reset), .i_start(start),
    .o_det_in0(b_in0), .o_det_in1(b_in1), .o_det_in2(b_in2), .i_det_out(b_det_out),
    .o_busy(b_busy), .o_done(b_done), .o_pass(b_pass), .o_err_count(b_err),
    .o_first_fail_valid(b_ffv), .o_first_fail_idx(b_ffi)
  );

  function automatic logic det_model(input int md, input logic a, input logic b, input logic c);
    logic maj;
    maj = (a & b) | (b & c) | (a & c);
    case (md)
      M_STUCK: return 1'b0;
      M_OR:    return a | b | c;
      M_INV:   return ~maj;
      default: return maj;
    endcase
  endfunction

  always_comb begin
    det_out   = det_model(mode, in0, in1, in2);
    b_det_out = det_model(M_INV, b_in0, b_in1, b_in2);
  end

  // Walks the eight patterns independently of the DUT to predict its report.
  task automatic predict(input int md, input int w, output int e, output int fv, output int fi);
    logic [2:0] p;
    logic       maj, d;
    e = 0; fv = 0; fi = 0;
    for (int i = 0; i < 8; i++) begin
      p   = 3'(i);
      maj = (p[2] & p[1]) | (p[1] & p[0]) | (p[2] & p[0]);
      d   = det_model(md, p[2], p[1], p[0]);
      if (d != maj) begin
        if (e < (1 << w) - 1) e++;
        if (fv == 0) begin
          fv = 1;
          fi = i;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_err"},  32'(err), 0);
    chk({tag, "_ffv"},  32'(ffv), 0);
    chk({tag, "_ffi"},  32'(ffi), 0);
    chk({tag, "_det"},  32'({in0, in1, in2}), 0);
    chk({tag, "_b_err"}, 32'(b_err), 0);
  endtask

  // One sweep from IDLE/DONE. noisy pulses start mid-sweep; abort_c >= 0 resets at that cycle.
  task automatic run_sweep(input int md, input bit noisy, input int abort_c);
    exp_t e;
    mode = md;
    if (abort_c < 0) begin
      predict(md, 4, e.err, e.ffv, e.ffi);
      predict(M_INV, 2, e.err2, e.ffv2, e.ffi2);
      e.pass = (e.err == 0) ? 1 : 0;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == abort_c) begin
        reset = 1'b1;
        #1;
        chk_idle_outputs("abort");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_abort");
        return;
      end
      chk("busy", 32'(busy), 1);
      chk("done_early", 32'(done), 0);
      chk("det_pattern", 32'({in0, in1, in2}), 32'(c / 2));
      if (c == 0) begin
        chk("err_cleared", 32'(err), 0);
        chk("ffv_cleared", 32'(ffv), 0);
      end
      start = (noisy && (c == 3 || c == 10)) ? 1'b1 : 1'b0;
    end
    @(negedge clk);
    chk("done", 32'(done), 1);
    chk("busy_end", 32'(busy), 0);
    chk("det_done", 32'({in0, in1, in2}), 0);
    chk("b_done", 32'(b_done), 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 0, 1);
    end else begin
      e = sb.pop_front();
      chk("err_count", 32'(err), 32'(e.err));
      chk("ff_valid", 32'(ffv), 32'(e.ffv));
      chk("ff_idx", 32'(ffi), 32'(e.ffi));
      chk("pass", 32'(pass), 32'(e.pass));
      chk("b_err_count", 32'(b_err), 32'(e.err2));
      chk("b_ff_valid", 32'(b_ffv), 32'(e.ffv2));
      chk("b_ff_idx", 32'(b_ffi), 32'(e.ffi2));
      chk("b_pass", 32'(b_pass), 0);
    end
    // Results must hold in DONE while start stays low.
    repeat (3) @(negedge clk);
    chk("done_hold", 32'(done), 1);
  endtask

  initial begin
    #12;
    chk_idle_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("idle");

    run_sweep(M_IDEAL, 1'b0, -1);
    run_sweep(M_STUCK, 1'b0, -1);
    run_sweep(M_OR,    1'b0, -1);
    run_sweep(M_IDEAL, 1'b1, -1);
    run_sweep(M_STUCK, 1'b0, 8);
    run_sweep(M_IDEAL, 1'b0, -1);

    chk("sb_drained", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
